// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the byte-wide RAM port arbiter.
// Holds the state encoding, size codes and address/length helpers.
package mem_arb_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_IC_RD = 2'd1;
    localparam logic [1:0] S_LS_RD = 2'd2;
    localparam logic [1:0] S_LS_WR = 2'd3;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic {
        G_IC,
        G_LS
    } grant_t;

    function automatic logic is_io(input logic [31:0] a, input logic [1:0] hi);
        return a[17:16] == hi;
    endfunction

    function automatic logic [2:0] size_to_len(input logic [1:0] s);
        unique case (s)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Request, response and RAM-side signals of the memory arbiter.
// master is the arbiter's view, slave the environment's view.
interface mem_arb_if #(
    parameter int LINE_BYTES = 16
);
    logic                    rdy;
    logic                    flush;
    logic                    ic_req;
    logic [31:0]             ic_addr;
    logic                    ic_done;
    logic [8*LINE_BYTES-1:0] ic_line;
    logic                    ls_req;
    logic                    ls_we;
    logic [1:0]              ls_size;
    logic [31:0]             ls_addr;
    logic [31:0]             ls_wdata;
    logic                    ls_done;
    logic [31:0]             ls_rdata;
    logic [7:0]              mem_din;
    logic [7:0]              mem_dout;
    logic [31:0]             mem_a;
    logic                    mem_wr;
    logic                    io_buffer_full;

    modport master (
        input  rdy, flush, ic_req, ic_addr,
        input  ls_req, ls_we, ls_size, ls_addr, ls_wdata,
        input  mem_din, io_buffer_full,
        output ic_done, ic_line, ls_done, ls_rdata,
        output mem_dout, mem_a, mem_wr
    );

    modport slave (
        output rdy, flush, ic_req, ic_addr,
        output ls_req, ls_we, ls_size, ls_addr, ls_wdata,
        output mem_din, io_buffer_full,
        input  ic_done, ic_line, ls_done, ls_rdata,
        input  mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_byte_seq.sv
// Byte sequencer: issue counter, address generation and read-return tracking.
// A freeze rewinds issue to the first byte not yet received.
module mem_byte_seq #(
    parameter int MAX_LEN = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic                           start,
    input  logic [31:0]                    start_addr,
    input  logic                           rd_en,
    input  logic                           wr_adv,
    input  logic [$clog2(MAX_LEN):0]       len,
    output logic [31:0]                    addr,
    output logic [$clog2(MAX_LEN):0]       cnt,
    output logic                           rd_stb,
    output logic [$clog2(MAX_LEN):0]       rd_idx
);
    localparam int CW = $clog2(MAX_LEN) + 1;

    logic [31:0]   base;
    logic [CW-1:0] rcv;
    logic          pend;
    logic          rdy_q;

    assign addr   = base + {{(32-CW){1'b0}}, cnt};
    assign rd_idx = rcv;
    assign rd_stb = rd_en & rdy & rdy_q & pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            base  <= '0;
            cnt   <= '0;
            rcv   <= '0;
            pend  <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= rdy;
            if (rdy) begin
                if (start) begin
                    base <= start_addr;
                    cnt  <= '0;
                    rcv  <= '0;
                    pend <= 1'b0;
                end else if (rd_en) begin
                    // mem_din no longer matches after a freeze
                    if (!rdy_q) begin
                        cnt  <= rcv;
                        pend <= 1'b0;
                    end else begin
                        pend <= (cnt < len);
                        if (cnt < len)
                            cnt <= cnt + 1'b1;
                        if (pend)
                            rcv <= rcv + 1'b1;
                    end
                end else begin
                    pend <= 1'b0;
                    if (wr_adv)
                        cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of the byte-wide RAM port between i-cache fills
// and the load/store buffer; assembles read data little-endian.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int         LINE_BYTES = 16,
    parameter logic [1:0] IO_HI      = 2'b11
) (
    input  logic      clk,
    input  logic      rst,
    mem_arb_if.master bus
);
    localparam int CW = $clog2(LINE_BYTES) + 1;

    logic [1:0]              state;
    grant_t                  last_grant;
    logic [CW-1:0]           len;
    logic [31:0]             wdata_q;
    logic                    ic_done_q;
    logic                    ls_done_q;
    logic [8*LINE_BYTES-1:0] line_q;
    logic [31:0]             rdata_q;

    logic [31:0]   addr;
    logic [CW-1:0] cnt;
    logic          rd_stb;
    logic [CW-1:0] rd_idx;

    logic        ic_ok;
    logic        pick_ls;
    logic        pick_ic;
    logic        start;
    logic [31:0] start_addr;
    logic        rd_en;
    logic        stall;
    logic        wr_adv;
    logic        rd_last;
    logic        wr_last;
    logic [31:0] wsh;

    always_comb begin
        ic_ok      = bus.ic_req & ~bus.flush;
        pick_ls    = bus.ls_req & (~ic_ok | (last_grant == G_IC));
        pick_ic    = ic_ok & ~pick_ls;
        start      = (state == S_IDLE) & ~(ic_done_q | ls_done_q)
                   & (pick_ls | pick_ic);
        start_addr = pick_ls ? bus.ls_addr : bus.ic_addr;
        rd_en      = (state == S_IC_RD) | (state == S_LS_RD);
        stall      = (state == S_LS_WR) & is_io(addr, IO_HI)
                   & bus.io_buffer_full;
        wr_adv     = (state == S_LS_WR) & ~stall;
        rd_last    = rd_stb & (rd_idx == len - CW'(1));
        wr_last    = wr_adv & (cnt == len - CW'(1));
        wsh        = wdata_q >> {cnt[1:0], 3'b000};
    end

    assign bus.mem_a    = addr;
    assign bus.mem_wr   = wr_adv & bus.rdy;
    assign bus.mem_dout = wsh[7:0];
    assign bus.ic_done  = ic_done_q;
    assign bus.ls_done  = ls_done_q;
    assign bus.ic_line  = line_q;
    assign bus.ls_rdata = rdata_q;

    mem_byte_seq #(
        .MAX_LEN (LINE_BYTES)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .rdy        (bus.rdy),
        .start      (start),
        .start_addr (start_addr),
        .rd_en      (rd_en),
        .wr_adv     (wr_adv),
        .len        (len),
        .addr       (addr),
        .cnt        (cnt),
        .rd_stb     (rd_stb),
        .rd_idx     (rd_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= G_IC;
            len        <= '0;
            wdata_q    <= '0;
            ic_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            line_q     <= '0;
            rdata_q    <= '0;
        end else if (bus.rdy) begin
            ic_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start && pick_ls) begin
                        last_grant <= G_LS;
                        len        <= CW'(size_to_len(bus.ls_size));
                        wdata_q    <= bus.ls_wdata;
                        state      <= bus.ls_we ? S_LS_WR : S_LS_RD;
                        if (!bus.ls_we)
                            rdata_q <= '0;
                    end else if (start) begin
                        last_grant <= G_IC;
                        len        <= CW'(LINE_BYTES);
                        state      <= S_IC_RD;
                    end
                end
                S_IC_RD: begin
                    // a flush drops the byte returning this cycle
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else if (rd_stb) begin
                        line_q[{rd_idx, 3'b000} +: 8] <= bus.mem_din;
                        if (rd_last) begin
                            ic_done_q <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                end
                S_LS_RD: begin
                    if (rd_stb) begin
                        rdata_q[{rd_idx[1:0], 3'b000} +: 8] <= bus.mem_din;
                        if (rd_last) begin
                            ls_done_q <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                end
                S_LS_WR: begin
                    if (wr_last) begin
                        ls_done_q <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
